// File: rtl/mc_fetch_ctrl.sv
// mc_fetch_ctrl: multi-cycle MIPS main controller sequencing fetch, decode, execute, memory and writeback.
// Controls are decoded combinationally from the current state; a memory-stall watchdog parks the core in HALT.
module mc_fetch_ctrl #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             dm_re,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  // state  | meaning
  // FETCH  | wait for im_ready, load IR, PC <= PC+4
  // DECODE | jumps and nop/illegal retire here
  // EXEC   | ALU operation, beq resolves and retires
  // MEM    | lw/sw data memory handshake
  // WB     | GRF write of ALU result or load data
  // HALT   | memory timeout, left only by reset
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam int WW = $clog2(WAIT_LIMIT + 1);

  state_t        st;
  logic [WW-1:0] wait_cnt;
  logic          waiting;

  logic is_r, i_addu, i_subu, i_jr, i_nop, i_ori, i_lui;
  logic i_lw, i_sw, i_beq, i_j, i_jal, i_ill;

  assign is_r   = (opcode == 6'b000000);
  assign i_addu = is_r && (funct == 6'b100001);
  assign i_subu = is_r && (funct == 6'b100011);
  assign i_jr   = is_r && (funct == 6'b001000);
  assign i_nop  = is_r && (funct == 6'b000000);
  assign i_ori  = (opcode == 6'b001101);
  assign i_lui  = (opcode == 6'b001111);
  assign i_lw   = (opcode == 6'b100011);
  assign i_sw   = (opcode == 6'b101011);
  assign i_beq  = (opcode == 6'b000100);
  assign i_j    = (opcode == 6'b000010);
  assign i_jal  = (opcode == 6'b000011);
  assign i_ill  = !(i_addu || i_subu || i_jr || i_nop || i_ori || i_lui ||
                    i_lw || i_sw || i_beq || i_j || i_jal);

  assign state   = st;
  assign waiting = ((st == FETCH) && !im_ready) || ((st == MEM) && !dm_ready);

  always_comb begin
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    alu_src    = 1'b0;
    alu_op     = 2'd0;
    ext_op     = 1'b0;
    dm_re      = 1'b0;
    dm_we      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    // Nothing may write while reset is held, even though FETCH is already current.
    if (reset) begin
      if (st == EXEC || st == MEM || st == WB) begin
        if (i_subu || i_beq)   alu_op = 2'd1;
        else if (i_ori)        alu_op = 2'd2;
        else if (i_lui)        alu_op = 2'd3;
        alu_src = i_ori || i_lui || i_lw || i_sw;
        ext_op  = i_lw || i_sw;
      end
      unique case (st)
        FETCH: begin
          ir_we = im_ready;
          pc_we = im_ready;
        end
        DECODE: begin
          if (i_j || i_jal) begin
            pc_we  = 1'b1;
            pc_sel = 2'd2;
          end
          if (i_jal) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
          if (i_jr) begin
            pc_we  = 1'b1;
            pc_sel = 2'd3;
          end
          instr_done = i_j || i_jal || i_jr || i_nop || i_ill;
          illegal    = i_ill;
        end
        EXEC: begin
          if (i_beq) begin
            pc_we      = zero;
            pc_sel     = 2'd1;
            instr_done = 1'b1;
          end
        end
        MEM: begin
          dm_re      = i_lw;
          dm_we      = i_sw;
          instr_done = i_sw && dm_ready;
        end
        WB: begin
          reg_we     = 1'b1;
          reg_dst    = is_r ? 2'd1 : 2'd0;
          wd_sel     = i_lw ? 2'd1 : 2'd0;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= FETCH;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if (instr_done) instr_cnt <= instr_cnt + 1'b1;
      if (waiting) begin
        // The WAIT_LIMIT-th consecutive stalled cycle trips the watchdog; ready that cycle avoids it.
        if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
          timeout  <= 1'b1;
          st       <= HALT;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
        case (st)
          FETCH:   st <= DECODE;
          DECODE:  st <= (i_j || i_jal || i_jr || i_nop || i_ill) ? FETCH : EXEC;
          EXEC: begin
            if (i_beq)             st <= FETCH;
            else if (i_lw || i_sw) st <= MEM;
            else                   st <= WB;
          end
          MEM:     st <= i_lw ? WB : FETCH;
          WB:      st <= FETCH;
          HALT:    st <= HALT;
          default: st <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mc_fetch_ctrl.sv
// tb_mc_fetch_ctrl: random instruction stream against an instruction-recipe reference model.
module tb_mc_fetch_ctrl;

  localparam int WL = 4;

  localparam int ADDU = 0, SUBU = 1, JR = 2, NOP = 3, ORI = 4, LUI = 5, LW = 6;
  localparam int SW = 7, BEQ = 8, J = 9, JAL = 10, ILL = 11, ILL_FF = 12;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       dm_re;
    logic       dm_we;
    logic       done;
    logic       ill;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, im_ready, dm_ready;
  logic       pc_we, ir_we, reg_we, alu_src, ext_op, dm_re, dm_we;
  logic       instr_done, illegal, timeout;
  logic [1:0] pc_sel, reg_dst, wd_sel, alu_op;
  logic [2:0] state;
  logic [7:0] instr_cnt;
  logic [19:0] act;

  int n_chk = 0;
  int n_err = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  mc_fetch_ctrl #(.CNT_W(8), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .im_ready(im_ready), .dm_ready(dm_ready), .pc_we(pc_we), .pc_sel(pc_sel),
    .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .dm_re(dm_re),
    .dm_we(dm_we), .state(state), .instr_done(instr_done), .illegal(illegal),
    .timeout(timeout), .instr_cnt(instr_cnt)
  );

  assign act = {state, pc_we, pc_sel, ir_we, reg_we, reg_dst, wd_sel,
                alu_src, alu_op, ext_op, dm_re, dm_we, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input ctrl_t e);
    @(negedge clk);
    check(tag, 32'(act), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Inputs the current phase does not care about are scrambled every cycle.
  task automatic noise();
    im_ready = 1'($urandom);
    dm_ready = 1'($urandom);
    zero     = 1'($urandom);
  endtask

  task automatic set_ins(input int c);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    case (c)
      ADDU: begin opcode = 6'b000000; funct = 6'b100001; end
      SUBU: begin opcode = 6'b000000; funct = 6'b100011; end
      JR:   begin opcode = 6'b000000; funct = 6'b001000; end
      NOP:  begin opcode = 6'b000000; funct = 6'b000000; end
      ORI:  opcode = 6'b001101;
      LUI:  opcode = 6'b001111;
      LW:   opcode = 6'b100011;
      SW:   opcode = 6'b101011;
      BEQ:  opcode = 6'b000100;
      J:    opcode = 6'b000010;
      JAL:  opcode = 6'b000011;
      ILL_FF: opcode = 6'b111111;
      default: begin
        case ($urandom_range(0, 2))
          0:       opcode = 6'b111111;
          1:       begin opcode = 6'b000000; funct = 6'b111111; end
          default: opcode = 6'b000101;
        endcase
      end
    endcase
  endtask

  task automatic retire();
    model_cnt++;
    check("instr_cnt", 32'(instr_cnt), 32'(model_cnt % 256));
    check("timeout_clear", 32'(timeout), 32'd0);
  endtask

  task automatic halt_check();
    ctrl_t e;
    e = '0;
    e.st = 3'd5;
    for (int i = 0; i < 3; i++) begin
      noise();
      im_ready = 1'b1;
      dm_ready = 1'b1;
      step("halt", e);
    end
    check("timeout_set", 32'(timeout), 32'd1);
    check("halt_cnt", 32'(instr_cnt), 32'(model_cnt % 256));
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    im_ready = 1'b1;
    dm_ready = 1'b1;
    #2;
    check("rst_ctrl", 32'(act), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_cnt = 0;
  endtask

  // One instruction end to end: fw / mw stalled cycles before im_ready / dm_ready.
  task automatic run_instr(input int c, input logic z, input int fw, input int mw);
    ctrl_t e, a;
    a = '0;
    case (c)
      SUBU, BEQ: a.alu_op = 2'd1;
      ORI:       begin a.alu_op = 2'd2; a.alu_src = 1'b1; end
      LUI:       begin a.alu_op = 2'd3; a.alu_src = 1'b1; end
      LW, SW:    begin a.alu_src = 1'b1; a.ext_op = 1'b1; end
      default: ;
    endcase
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    for (int i = 0; i < fw && i < WL; i++) begin
      noise();
      im_ready = 1'b0;
      e = '0;
      step("fetch_wait", e);
    end
    if (fw >= WL) begin
      halt_check();
      return;
    end
    noise();
    im_ready = 1'b1;
    e = '0;
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    step("fetch", e);

    set_ins(c);
    noise();
    e = '0;
    e.st = 3'd1;
    case (c)
      J:   begin e.pc_we = 1'b1; e.pc_sel = 2'd2; e.done = 1'b1; end
      JAL: begin
        e.pc_we = 1'b1; e.pc_sel = 2'd2; e.done = 1'b1;
        e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
      end
      JR:  begin e.pc_we = 1'b1; e.pc_sel = 2'd3; e.done = 1'b1; end
      NOP: e.done = 1'b1;
      ILL, ILL_FF: begin e.done = 1'b1; e.ill = 1'b1; end
      default: ;
    endcase
    step("decode", e);
    if (e.done) begin
      retire();
      return;
    end

    noise();
    e = a;
    e.st = 3'd2;
    if (c == BEQ) begin
      zero = z;
      e.pc_we = z;
      e.pc_sel = 2'd1;
      e.done = 1'b1;
      step("exec_beq", e);
      retire();
      return;
    end
    step("exec", e);

    if (c == LW || c == SW) begin
      for (int i = 0; i < mw && i < WL; i++) begin
        noise();
        dm_ready = 1'b0;
        e = a;
        e.st = 3'd3;
        e.dm_re = (c == LW);
        e.dm_we = (c == SW);
        step("mem_wait", e);
      end
      if (mw >= WL) begin
        halt_check();
        return;
      end
      noise();
      dm_ready = 1'b1;
      e = a;
      e.st = 3'd3;
      e.dm_re = (c == LW);
      e.dm_we = (c == SW);
      e.done = (c == SW);
      step("mem", e);
      if (c == SW) begin
        retire();
        return;
      end
    end

    noise();
    e = a;
    e.st = 3'd4;
    e.reg_we = 1'b1;
    e.reg_dst = (c == ADDU || c == SUBU) ? 2'd1 : 2'd0;
    e.wd_sel = (c == LW) ? 2'd1 : 2'd0;
    e.done = 1'b1;
    step("wb", e);
    retire();
  endtask

  initial begin
    ctrl_t e;
    reset = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    im_ready = 1'b0;
    dm_ready = 1'b0;
    do_reset();

    run_instr(ADDU, 1'b0, 0, 0);
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
    run_instr(LW, 1'b0, 0, 3);
    run_instr(SW, 1'b0, 0, 3);
    run_instr(JAL, 1'b0, 0, 0);
    run_instr(J, 1'b0, 0, 0);
    run_instr(JR, 1'b0, 0, 0);
    run_instr(ILL_FF, 1'b0, 0, 0);
    run_instr(ORI, 1'b0, 3, 0);
    run_instr(LUI, 1'b0, 1, 0);

    // Long enough to wrap the 8-bit retire counter.
    for (int n = 0; n < 300; n++)
      run_instr($urandom_range(0, 12), 1'($urandom), $urandom_range(0, WL - 1),
                $urandom_range(0, WL - 1));

    do_reset();
    run_instr(ADDU, 1'b0, WL, 0);
    do_reset();
    run_instr(LW, 1'b0, 0, WL);
    do_reset();
    run_instr(SW, 1'b0, 1, WL);

    do_reset();
    run_instr(ADDU, 1'b0, 0, 0);
    set_ins(SW);
    im_ready = 1'b1;
    dm_ready = 1'b0;
    e = '0;
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    step("rs_fetch", e);
    e = '0;
    e.st = 3'd1;
    step("rs_decode", e);
    e = '0;
    e.st = 3'd2;
    e.alu_src = 1'b1;
    e.ext_op = 1'b1;
    step("rs_exec", e);
    @(negedge clk);
    e.st = 3'd3;
    e.dm_we = 1'b1;
    check("rs_mem", 32'(act), 32'(e));
    #2 reset = 1'b0;
    #1;
    check("rs_drop", 32'(act), 32'd0);
    check("rs_cnt", 32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_cnt = 0;
    run_instr(ILL_FF, 1'b0, 0, 0);
    run_instr(ADDU, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
